// File: rtl/data_mem_resp.sv
// Data memory with a posted-write FIFO buffer and a fixed two-cycle read pipeline.
// Define DMEM_FWD_EN to let reads forward from the write buffer instead of waiting for it to drain.
module data_mem_resp #(
    parameter int DEPTH    = 256,
    parameter int WB_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        writeFlag,
    input  logic        readFlag,
    input  logic [31:0] addressIn,
    input  logic [31:0] dataIn,
    output logic [31:0] dataOut,
    output logic        readValid,
    output logic        busy
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = (WB_DEPTH > 1) ? $clog2(WB_DEPTH) : 1;
    localparam int CW = $clog2(WB_DEPTH) + 1;

    typedef enum logic [1:0] {IDLE, RD1, RD2} state_t;
    typedef logic [PW-1:0] ptr_t;

    localparam ptr_t          PTR_LAST = ptr_t'(WB_DEPTH - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(WB_DEPTH);

    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == PTR_LAST) ? '0 : p + ptr_t'(1);
    endfunction

    state_t        state, state_next;
    logic [31:0]   mem     [DEPTH];
    logic [AW-1:0] wb_addr [WB_DEPTH];
    logic [31:0]   wb_data [WB_DEPTH];
    ptr_t          wr_ptr, rd_ptr;
    logic [CW-1:0] wb_count;
    logic [AW-1:0] req_idx, rd_idx;
    logic          wb_full, wb_empty, wr_acc, rd_acc, rd_allowed, drain;
    logic          fwd_hit_c, fwd_hit;
    logic [31:0]   fwd_data_c, fwd_data;
    logic          unused_addr;

    // Only the word-index bits select a location; the rest of the address aliases.
    assign req_idx     = addressIn[AW+1:2];
    assign unused_addr = ^{addressIn[31:AW+2], addressIn[1:0]};

    assign wb_full   = (wb_count == CNT_FULL);
    assign wb_empty  = (wb_count == '0);
    assign drain     = !wb_empty && (state != RD1);
    assign wr_acc    = writeFlag && !wb_full;
    assign rd_acc    = readFlag && !writeFlag && (state != RD1) && rd_allowed;
    assign busy      = (writeFlag && wb_full) || (readFlag && !rd_acc);
    assign readValid = (state == RD2);

`ifdef DMEM_FWD_EN
    assign rd_allowed = 1'b1;

    // Walk oldest to youngest so the youngest matching entry wins.
    always_comb begin
        fwd_hit_c  = 1'b0;
        fwd_data_c = '0;
        for (int i = 0; i < WB_DEPTH; i++) begin
            if (i < int'(wb_count) &&
                wb_addr[ptr_t'((int'(rd_ptr) + i) % WB_DEPTH)] == req_idx) begin
                fwd_hit_c  = 1'b1;
                fwd_data_c = wb_data[ptr_t'((int'(rd_ptr) + i) % WB_DEPTH)];
            end
        end
    end
`else
    assign rd_allowed = wb_empty;
    assign fwd_hit_c  = 1'b0;
    assign fwd_data_c = '0;
`endif

    // NOTE: next_state gets its default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (rd_acc) state_next = RD1;
            RD1:     state_next = RD2;
            RD2:     state_next = rd_acc ? RD1 : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            wb_count <= '0;
            rd_idx   <= '0;
            fwd_hit  <= 1'b0;
            fwd_data <= '0;
            dataOut  <= '0;
        end else begin
            state <= state_next;
            if (wr_acc) wr_ptr <= ptr_inc(wr_ptr);
            if (drain)  rd_ptr <= ptr_inc(rd_ptr);
            if (wr_acc && !drain)      wb_count <= wb_count + CW'(1);
            else if (drain && !wr_acc) wb_count <= wb_count - CW'(1);
            if (rd_acc) begin
                rd_idx   <= req_idx;
                fwd_hit  <= fwd_hit_c;
                fwd_data <= fwd_data_c;
            end
            if (state == RD1) dataOut <= fwd_hit ? fwd_data : mem[rd_idx];
        end
    end

    // NOTE: storage arrays have no reset; validity is tracked by the pointers and count alone.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            wb_addr[wr_ptr] <= req_idx;
            wb_data[wr_ptr] <= dataIn;
        end
        if (drain) mem[wb_addr[rd_ptr]] <= wb_data[rd_ptr];
    end

endmodule

// File: tb/tb_data_mem_resp.sv
// Scoreboard bench for data_mem_resp: reads push expected data, a negedge monitor pops on readValid.
// A second instance with a one-entry write buffer exercises the full-buffer stall.
module tb_data_mem_resp;
`ifdef DMEM_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        writeFlag0 = 1'b0, readFlag0 = 1'b0;
    logic        writeFlag1 = 1'b0, readFlag1 = 1'b0;
    logic [31:0] addressIn = '0, dataIn = '0;
    logic [31:0] dataOut0, dataOut1;
    logic        readValid0, readValid1, busy0, busy1;

    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;

    data_mem_resp u_dut0 (
        .clk(clk), .rst(rst), .writeFlag(writeFlag0), .readFlag(readFlag0),
        .addressIn(addressIn), .dataIn(dataIn),
        .dataOut(dataOut0), .readValid(readValid0), .busy(busy0)
    );

    data_mem_resp #(.DEPTH(16), .WB_DEPTH(1)) u_dut1 (
        .clk(clk), .rst(rst), .writeFlag(writeFlag1), .readFlag(readFlag1),
        .addressIn(addressIn), .dataIn(dataIn),
        .dataOut(dataOut1), .readValid(readValid1), .busy(busy1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic busy_of(input bit sel);
        return sel ? busy1 : busy0;
    endfunction

    task automatic set_flags(input bit sel, input logic w, input logic r);
        if (sel) begin
            writeFlag1 = w;
            readFlag1  = r;
        end else begin
            writeFlag0 = w;
            readFlag0  = r;
        end
    endtask

    // Present a request at negedge, hold it while busy, return just after the accepting edge.
    task automatic req(input bit sel, input logic w, input logic r, input logic [31:0] a,
                       input logic [31:0] d, input bit push, output int stalls);
        exp_t e;
        @(negedge clk);
        addressIn = a;
        dataIn    = d;
        set_flags(sel, w, r);
        if (w && r) begin
            #1 check("both_flags_busy", 32'(busy_of(sel)), 32'd1);
            @(posedge clk);
            #1 set_flags(sel, 1'b0, r);
        end
        stalls = 0;
        #1;
        while (busy_of(sel) && stalls < 40) begin
            @(posedge clk);
            #1 stalls++;
        end
        if (stalls >= 40) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout: busy still high after %0d cycles, expected accept", stalls);
        end
        @(posedge clk);
        #1;
        if (push) begin
            e.data = d;
            e.due  = cyc + 2;
            if (sel) q1.push_back(e);
            else     q0.push_back(e);
        end
        set_flags(sel, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: readValid seen at negedge is sampled by the requester on the next rising edge.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (readValid0 === 1'b1) begin
                if (q0.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL dut0_unexpected_readValid: got pulse, expected none");
                end else begin
                    e0 = q0.pop_front();
                    check("dut0_data", dataOut0, e0.data);
                    check("dut0_latency", cyc + 1, e0.due);
                end
            end
            if (readValid1 === 1'b1) begin
                if (q1.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL dut1_unexpected_readValid: got pulse, expected none");
                end else begin
                    e1 = q1.pop_front();
                    check("dut1_data", dataOut1, e1.data);
                    check("dut1_latency", cyc + 1, e1.due);
                end
            end
        end
    end

    initial begin
        int s;
        #2 rst = 1'b0;
        idle(2);
        check("reset_dataOut", dataOut0, 32'h0);
        check("reset_readValid", 32'(readValid0), 32'd0);
        check("reset_busy", 32'(busy0), 32'd0);

        // Release mid-cycle: the first write must be taken on the very next rising edge.
        @(posedge clk);
        #2 rst = 1'b1;
        req(0, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, s);
        check("wr_first_edge_stalls", s, 32'd0);
        idle(6);
        req(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b1, s);
        check("rd_basic_stalls", s, 32'd0);
        req(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b1, s);
        check("rd_b2b_stalls", s, 32'd1);
        req(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b1, s);
        check("rd_b2b_stalls", s, 32'd1);
        idle(4);
        check("dataOut_hold", dataOut0, 32'hDEADBEEF);
        check("readValid_idle", 32'(readValid0), 32'd0);

        for (int i = 0; i < 5; i++) begin
            req(0, 1'b1, 1'b0, 32'h100 + 32'(i * 4), 32'h1000_0000 + 32'(i), 1'b0, s);
            check("wr_burst_stalls", s, 32'd0);
        end
        idle(3);
        for (int i = 0; i < 5; i++) begin
            req(0, 1'b0, 1'b1, 32'h100 + 32'(i * 4), 32'h1000_0000 + 32'(i), 1'b1, s);
            check("rd_burst_stalls", s, (i == 0) ? 32'd0 : 32'd1);
        end

        idle(3);
        req(0, 1'b1, 1'b0, 32'h20, 32'h11111111, 1'b0, s);
        req(0, 1'b1, 1'b0, 32'h20, 32'h22222222, 1'b0, s);
        req(0, 1'b0, 1'b1, 32'h20, 32'h22222222, 1'b1, s);
        check("rd_after_wr_stalls", s, FWD ? 32'd0 : 32'd1);

        idle(3);
        req(0, 1'b1, 1'b1, 32'h30, 32'h5, 1'b1, s);
        check("rd_after_both_stalls", s, FWD ? 32'd0 : 32'd1);

        idle(3);
        req(0, 1'b1, 1'b0, 32'h40, 32'h1, 1'b0, s);
        req(0, 1'b1, 1'b0, 32'h40, 32'h2, 1'b0, s);
        req(0, 1'b1, 1'b0, 32'h40, 32'h3, 1'b0, s);
        idle(4);
        req(0, 1'b0, 1'b1, 32'h40, 32'h3, 1'b1, s);
        check("rd_same_word_stalls", s, 32'd0);

        idle(3);
        req(0, 1'b1, 1'b0, 32'h400, 32'hA5, 1'b0, s);
        req(0, 1'b0, 1'b1, 32'h0, 32'hA5, 1'b1, s);
        check("rd_alias_stalls", s, FWD ? 32'd0 : 32'd1);

        // Kill a read while it sits in RD1; it must never return.
        idle(4);
        req(0, 1'b0, 1'b1, 32'h10, 32'h0, 1'b0, s);
        rst = 1'b0;
        #1;
        check("rst_rd1_readValid", 32'(readValid0), 32'd0);
        check("rst_rd1_dataOut", dataOut0, 32'h0);
        check("rst_rd1_busy", 32'(busy0), 32'd0);
        repeat (2) begin
            @(negedge clk);
            check("rst_hold_readValid", 32'(readValid0), 32'd0);
        end
        @(posedge clk);
        #2 rst = 1'b1;
        req(0, 1'b1, 1'b0, 32'h50, 32'hCAFEF00D, 1'b0, s);
        check("wr_after_rst_stalls", s, 32'd0);
        req(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b1, s);
        req(0, 1'b0, 1'b1, 32'h50, 32'hCAFEF00D, 1'b1, s);

        // One-entry buffer: a full buffer stalls the next write even while it drains.
        idle(4);
        req(1, 1'b1, 1'b0, 32'h4, 32'hAAAA0001, 1'b0, s);
        check("wb1_first_wr_stalls", s, 32'd0);
        req(1, 1'b1, 1'b0, 32'h8, 32'hBBBB0002, 1'b0, s);
        check("wb1_full_stalls", s, 32'd1);
        req(1, 1'b1, 1'b0, 32'h4, 32'hCCCC0003, 1'b0, s);
        check("wb1_full_stalls", s, 32'd1);
        req(1, 1'b0, 1'b1, 32'h4, 32'hCCCC0003, 1'b1, s);
        req(1, 1'b0, 1'b1, 32'h8, 32'hBBBB0002, 1'b1, s);

        for (int i = 0; i < 20 && (q0.size() != 0 || q1.size() != 0); i++) @(negedge clk);
        check("q0_drained", q0.size(), 32'd0);
        check("q1_drained", q1.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
